// File: rtl/la_cmd_pkg.sv
// Shared definitions for the logic-analyzer command processor.
// Holds the command opcode and FSM state encodings, the register
// address map used by the host, and the fixed acknowledge bytes.
package la_cmd_pkg;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_DUMP  = 2'b10,
        OP_NAK   = 2'b11
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RD_WAIT,
        ST_TX,
        ST_WAIT_SENT
    } state_e;

    // Register addresses (cmd[13:8]); channel registers occupy 0x01..NUM_CH.
    localparam logic [5:0] A_TRIG_CFG   = 6'h00;
    localparam logic [5:0] A_DECIMATOR  = 6'h09;
    localparam logic [5:0] A_VIH        = 6'h0A;
    localparam logic [5:0] A_VIL        = 6'h0B;
    localparam logic [5:0] A_MATCH_H    = 6'h0C;
    localparam logic [5:0] A_MATCH_L    = 6'h0D;
    localparam logic [5:0] A_MASK_H     = 6'h0E;
    localparam logic [5:0] A_MASK_L     = 6'h0F;
    localparam logic [5:0] A_BAUD_H     = 6'h10;
    localparam logic [5:0] A_BAUD_L     = 6'h11;
    localparam logic [5:0] A_TRIG_POS_H = 6'h12;
    localparam logic [5:0] A_TRIG_POS_L = 6'h13;

    localparam logic [7:0] ACK = 8'hA5;
    localparam logic [7:0] NAK = 8'hEE;

    localparam logic [5:0]  TRIG_CFG_RST = 6'h03;
    localparam logic [4:0]  CH_CFG_RST   = 5'h01;
    localparam logic [7:0]  VIH_RST      = 8'hAA;
    localparam logic [7:0]  VIL_RST      = 8'h55;
    localparam logic [15:0] BAUD_RST     = 16'h06C8;

endpackage

// File: rtl/la_cfg_regs.sv
// Configuration register file for the logic-analyzer core.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   wr_en, addr, wdata  one-cycle write strobe, register address, write byte
//   set_capture_done    pulse: set trig_cfg[5], clear trig_cfg[4]
//   rd_data, addr_ok    combinational read mux, high when addr is mapped
//   trig_cfg .. trig_pos register contents
// Channel c (1-based) occupies ch_trig_cfg[5c-1:5c-5].
module la_cfg_regs
    import la_cmd_pkg::*;
#(
    parameter int NUM_CH = 5,
    parameter int LOG2   = 9
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [5:0]          addr,
    input  logic [7:0]          wdata,
    input  logic                set_capture_done,
    output logic [7:0]          rd_data,
    output logic                addr_ok,
    output logic [5:0]          trig_cfg,
    output logic [5*NUM_CH-1:0] ch_trig_cfg,
    output logic [3:0]          decimator,
    output logic [7:0]          vih,
    output logic [7:0]          vil,
    output logic [15:0]         match,
    output logic [15:0]         mask,
    output logic [15:0]         baud_cnt,
    output logic [LOG2-1:0]     trig_pos
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_cfg    <= TRIG_CFG_RST;
            ch_trig_cfg <= {NUM_CH{CH_CFG_RST}};
            decimator   <= 4'h0;
            vih         <= VIH_RST;
            vil         <= VIL_RST;
            match       <= 16'h0000;
            mask        <= 16'h0000;
            baud_cnt    <= BAUD_RST;
            trig_pos    <= LOG2'(1);
        end else begin
            // Capture-done is applied first so a same-cycle host write wins.
            if (set_capture_done) begin
                trig_cfg[5] <= 1'b1;
                trig_cfg[4] <= 1'b0;
            end
            if (wr_en) begin
                case (addr)
                    A_TRIG_CFG:   trig_cfg         <= wdata[5:0];
                    A_DECIMATOR:  decimator        <= wdata[3:0];
                    A_VIH:        vih              <= wdata;
                    A_VIL:        vil              <= wdata;
                    A_MATCH_H:    match[15:8]      <= wdata;
                    A_MATCH_L:    match[7:0]       <= wdata;
                    A_MASK_H:     mask[15:8]       <= wdata;
                    A_MASK_L:     mask[7:0]        <= wdata;
                    A_BAUD_H:     baud_cnt[15:8]   <= wdata;
                    A_BAUD_L:     baud_cnt[7:0]    <= wdata;
                    A_TRIG_POS_H: trig_pos[LOG2-1:8] <= wdata[LOG2-9:0];
                    A_TRIG_POS_L: trig_pos[7:0]    <= wdata;
                    default: ;
                endcase
                for (int c = 1; c <= NUM_CH; c++) begin
                    if (addr == 6'(c)) ch_trig_cfg[5*(c-1) +: 5] <= wdata[4:0];
                end
            end
        end
    end

    always_comb begin
        rd_data = 8'h00;
        addr_ok = 1'b1;
        case (addr)
            A_TRIG_CFG:   rd_data = {2'b00, trig_cfg};
            A_DECIMATOR:  rd_data = {4'h0, decimator};
            A_VIH:        rd_data = vih;
            A_VIL:        rd_data = vil;
            A_MATCH_H:    rd_data = match[15:8];
            A_MATCH_L:    rd_data = match[7:0];
            A_MASK_H:     rd_data = mask[15:8];
            A_MASK_L:     rd_data = mask[7:0];
            A_BAUD_H:     rd_data = baud_cnt[15:8];
            A_BAUD_L:     rd_data = baud_cnt[7:0];
            A_TRIG_POS_H: rd_data = 8'(trig_pos >> 8);
            A_TRIG_POS_L: rd_data = trig_pos[7:0];
            default:      addr_ok = 1'b0;
        endcase
        // Channel registers: only 1..NUM_CH are mapped, the rest stay NAK.
        for (int c = 1; c <= NUM_CH; c++) begin
            if (addr == 6'(c)) begin
                rd_data = {3'b000, ch_trig_cfg[5*(c-1) +: 5]};
                addr_ok = 1'b1;
            end
        end
    end

endmodule

// File: rtl/la_cmd_ctrl.sv
// Host command processor for the logic-analyzer core.
// Decodes 16-bit commands (read / write / dump / NAK), answers each with
// one or more UART bytes, and streams RAM queue contents on dump.
// Ports:
//   cmd, cmd_rdy, clr_cmd_rdy   command in, held until the retire pulse
//   resp, send_resp, resp_sent  response byte and UART handshake
//   set_capture_done            capture unit status pulse
//   waddr, raddr, rdata         RAM queues (1-cycle read latency)
//   TrigCfg .. trig_pos         configuration register outputs
// Handshake: send_resp is a one-cycle pulse with resp already stable; the
// FSM then waits for a resp_sent pulse before doing anything else. resp_sent
// seen in any other state is ignored. clr_cmd_rdy pulses once per command,
// after its last resp_sent.
module la_cmd_ctrl
    import la_cmd_pkg::*;
#(
    parameter int NUM_CH  = 5,
    parameter int ENTRIES = 384,
    parameter int LOG2    = 9
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [15:0]         cmd,
    input  logic                cmd_rdy,
    output logic                clr_cmd_rdy,
    output logic [7:0]          resp,
    output logic                send_resp,
    input  logic                resp_sent,
    input  logic                set_capture_done,
    input  logic [LOG2-1:0]     waddr,
    output logic [LOG2-1:0]     raddr,
    input  logic [8*NUM_CH-1:0] rdata,
    output logic [5:0]          TrigCfg,
    output logic [5*NUM_CH-1:0] CHTrigCfg,
    output logic [3:0]          decimator,
    output logic [7:0]          VIH,
    output logic [7:0]          VIL,
    output logic [15:0]         match,
    output logic [15:0]         mask,
    output logic [15:0]         baud_cnt,
    output logic [LOG2-1:0]     trig_pos
);

    localparam logic [LOG2-1:0] LAST_ADDR = LOG2'(ENTRIES - 1);

    state_e          state, state_nxt;
    opcode_e         opcode;
    logic            all_ch;
    logic [2:0]      cmd_ch;
    logic            dump_ok;
    logic [7:0]      rd_data;
    logic            addr_ok;
    logic [7:0]      exec_byte;
    logic [7:0]      tx_byte;
    logic [2:0]      sel_ch;
    logic [LOG2-1:0] addr_cnt;
    logic [2:0]      ch_cnt;
    logic            wr_pend;
    logic            exec_resp, dump_start, tx_fire, step_ch, step_addr, retire;

    assign opcode  = opcode_e'(cmd[15:14]);
    assign all_ch  = cmd[11];
    assign cmd_ch  = cmd[10:8];
    assign dump_ok = (opcode == OP_DUMP) &&
                     (all_ch || (cmd_ch != 3'd0 && 32'(cmd_ch) <= NUM_CH));
    assign sel_ch  = all_ch ? ch_cnt : cmd_ch;

    // Writes land one cycle after the response is launched; cmd is still
    // held at that point because retirement needs resp_sent first.
    la_cfg_regs #(.NUM_CH(NUM_CH), .LOG2(LOG2)) u_regs (
        .clk              (clk),
        .rst_n            (rst_n),
        .wr_en            (wr_pend),
        .addr             (cmd[13:8]),
        .wdata            (cmd[7:0]),
        .set_capture_done (set_capture_done),
        .rd_data          (rd_data),
        .addr_ok          (addr_ok),
        .trig_cfg         (TrigCfg),
        .ch_trig_cfg      (CHTrigCfg),
        .decimator        (decimator),
        .vih              (VIH),
        .vil              (VIL),
        .match            (match),
        .mask             (mask),
        .baud_cnt         (baud_cnt),
        .trig_pos         (trig_pos)
    );

    always_comb begin
        exec_byte = NAK;
        case (opcode)
            OP_READ:  if (addr_ok) exec_byte = rd_data;
            OP_WRITE: if (addr_ok) exec_byte = ACK;
            default: ;
        endcase
    end

    always_comb begin
        tx_byte = 8'h00;
        for (int c = 0; c < NUM_CH; c++) begin
            if (sel_ch == 3'(c + 1)) tx_byte = rdata[8*c +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        exec_resp  = 1'b0;
        dump_start = 1'b0;
        tx_fire    = 1'b0;
        step_ch    = 1'b0;
        step_addr  = 1'b0;
        retire     = 1'b0;
        case (state)
            // clr_cmd_rdy is registered, so cmd_rdy is still high in the cycle
            // it pulses; ignore it then or the retired command would rerun.
            ST_IDLE: if (cmd_rdy && !clr_cmd_rdy) state_nxt = ST_EXEC;
            ST_EXEC: begin
                if (dump_ok) begin
                    dump_start = 1'b1;
                    state_nxt  = ST_RD_WAIT;
                end else begin
                    exec_resp = 1'b1;
                    state_nxt = ST_WAIT_SENT;
                end
            end
            ST_RD_WAIT: state_nxt = ST_TX;
            ST_TX: begin
                tx_fire   = 1'b1;
                state_nxt = ST_WAIT_SENT;
            end
            ST_WAIT_SENT: begin
                if (resp_sent) begin
                    if (!dump_ok) begin
                        retire    = 1'b1;
                        state_nxt = ST_IDLE;
                    end else if (all_ch && ch_cnt != 3'(NUM_CH)) begin
                        step_ch   = 1'b1;
                        state_nxt = ST_TX;
                    end else if (addr_cnt != LAST_ADDR) begin
                        step_addr = 1'b1;
                        state_nxt = ST_RD_WAIT;
                    end else begin
                        retire    = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp        <= 8'h00;
            send_resp   <= 1'b0;
            clr_cmd_rdy <= 1'b0;
            raddr       <= '0;
            addr_cnt    <= '0;
            ch_cnt      <= 3'd0;
            wr_pend     <= 1'b0;
        end else begin
            send_resp   <= exec_resp | tx_fire;
            clr_cmd_rdy <= retire;
            wr_pend     <= exec_resp && (opcode == OP_WRITE) && addr_ok;
            if (exec_resp)    resp <= exec_byte;
            else if (tx_fire) resp <= tx_byte;
            if (dump_start) begin
                raddr    <= waddr;
                addr_cnt <= '0;
                ch_cnt   <= 3'd1;
            end else if (step_addr) begin
                raddr    <= (raddr == LAST_ADDR) ? '0 : raddr + 1'b1;
                addr_cnt <= addr_cnt + 1'b1;
                ch_cnt   <= 3'd1;
            end else if (step_ch) begin
                ch_cnt   <= ch_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_la_cmd_ctrl.sv
module tb_la_cmd_ctrl;
    localparam int NUM_CH  = 5;
    localparam int ENTRIES = 384;
    localparam int LOG2    = 9;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [15:0]         cmd = 16'h0000;
    logic                cmd_rdy = 1'b0;
    logic                clr_cmd_rdy;
    logic [7:0]          resp;
    logic                send_resp;
    logic                resp_sent = 1'b0;
    logic                set_capture_done = 1'b0;
    logic [LOG2-1:0]     waddr = '0;
    logic [LOG2-1:0]     raddr;
    logic [8*NUM_CH-1:0] rdata = '0;
    logic [5:0]          TrigCfg;
    logic [5*NUM_CH-1:0] CHTrigCfg;
    logic [3:0]          decimator;
    logic [7:0]          VIH, VIL;
    logic [15:0]         match, mask, baud_cnt;
    logic [LOG2-1:0]     trig_pos;

    int checks = 0;
    int failures = 0;
    int clr_seen = 0;
    int n_cmds = 0;
    logic [7:0] exp_q[$];

    // Reference state: register contents and RAM queue contents.
    logic [5:0]      m_trig;
    logic [4:0]      m_ch[1:NUM_CH];
    logic [3:0]      m_dec;
    logic [7:0]      m_vih, m_vil;
    logic [15:0]     m_match, m_mask, m_baud;
    logic [LOG2-1:0] m_tpos;
    logic [7:0]      mem[NUM_CH][ENTRIES];

    la_cmd_ctrl #(.NUM_CH(NUM_CH), .ENTRIES(ENTRIES), .LOG2(LOG2)) dut (
        .clk(clk), .rst_n(rst_n), .cmd(cmd), .cmd_rdy(cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy), .resp(resp), .send_resp(send_resp),
        .resp_sent(resp_sent), .set_capture_done(set_capture_done),
        .waddr(waddr), .raddr(raddr), .rdata(rdata),
        .TrigCfg(TrigCfg), .CHTrigCfg(CHTrigCfg), .decimator(decimator),
        .VIH(VIH), .VIL(VIL), .match(match), .mask(mask),
        .baud_cnt(baud_cnt), .trig_pos(trig_pos)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog_timeout got=running required=finished");
        $fatal(1, "watchdog");
    end

    // RAM queues: one cycle read latency.
    always @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) rdata[8*c +: 8] <= mem[c][raddr];
    end

    // UART transmitter: acknowledges each send_resp after a random delay.
    initial begin
        forever begin
            @(negedge clk);
            if (send_resp) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                resp_sent = 1'b1;
                @(negedge clk);
                resp_sent = 1'b0;
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic void model_reset();
        m_trig = 6'h03; m_dec = 4'h0; m_vih = 8'hAA; m_vil = 8'h55;
        m_match = 16'h0; m_mask = 16'h0; m_baud = 16'h06C8; m_tpos = LOG2'(1);
        for (int c = 1; c <= NUM_CH; c++) m_ch[c] = 5'h01;
    endfunction

    function automatic bit model_mapped(input int a);
        return (a >= 0 && a <= NUM_CH) || (a >= 9 && a <= 19);
    endfunction

    function automatic logic [7:0] model_read(input int a);
        logic [15:0] tp16;
        tp16 = 16'(m_tpos);
        if (a == 0) return {2'b00, m_trig};
        if (a >= 1 && a <= NUM_CH) return {3'b000, m_ch[a]};
        case (a)
            9:  return {4'h0, m_dec};
            10: return m_vih;
            11: return m_vil;
            12: return m_match[15:8];
            13: return m_match[7:0];
            14: return m_mask[15:8];
            15: return m_mask[7:0];
            16: return m_baud[15:8];
            17: return m_baud[7:0];
            18: return tp16[15:8];
            19: return tp16[7:0];
            default: return 8'h00;
        endcase
    endfunction

    function automatic void model_write(input int a, input logic [7:0] d);
        if (a == 0) m_trig = d[5:0];
        else if (a >= 1 && a <= NUM_CH) m_ch[a] = d[4:0];
        else case (a)
            9:  m_dec = d[3:0];
            10: m_vih = d;
            11: m_vil = d;
            12: m_match = {d, m_match[7:0]};
            13: m_match = {m_match[15:8], d};
            14: m_mask = {d, m_mask[7:0]};
            15: m_mask = {m_mask[15:8], d};
            16: m_baud = {d, m_baud[7:0]};
            17: m_baud = {m_baud[15:8], d};
            18: m_tpos = LOG2'({d, m_tpos[7:0]});
            19: m_tpos = LOG2'({8'(m_tpos >> 8), d});
            default: ;
        endcase
    endfunction

    // Pushes every byte the host should receive for command c.
    function automatic void push_expected(input logic [15:0] c);
        int a, ch, base;
        a  = int'(c[13:8]);
        ch = int'(c[10:8]);
        case (c[15:14])
            2'b00: exp_q.push_back(model_mapped(a) ? model_read(a) : 8'hEE);
            2'b01: begin
                if (model_mapped(a)) begin
                    model_write(a, c[7:0]);
                    exp_q.push_back(8'hA5);
                end else exp_q.push_back(8'hEE);
            end
            2'b10: begin
                if (!c[11] && (ch < 1 || ch > NUM_CH)) exp_q.push_back(8'hEE);
                else begin
                    base = int'(waddr);
                    for (int i = 0; i < ENTRIES; i++) begin
                        if (c[11]) begin
                            for (int k = 0; k < NUM_CH; k++)
                                exp_q.push_back(mem[k][(base + i) % ENTRIES]);
                        end else exp_q.push_back(mem[ch-1][(base + i) % ENTRIES]);
                    end
                end
            end
            default: exp_q.push_back(8'hEE);
        endcase
    endfunction

    // ---------------- scoreboard / monitor ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s got=%0h required=%0h", name, act, expv);
        end
    endtask

    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && send_resp) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL resp_unexpected got=%0h required=none", resp);
                end else begin
                    e = exp_q.pop_front();
                    if (resp !== e) begin
                        failures++;
                        $display("FAIL resp_byte got=%0h required=%0h", resp, e);
                    end
                end
            end
            if (rst_n && clr_cmd_rdy) begin
                clr_seen++;
                checks++;
                if (exp_q.size() != 0) begin
                    failures++;
                    $display("FAIL clr_early pending=%0d required=0", exp_q.size());
                end
            end
        end
    end

    task automatic check_outputs(input string tag);
        chk({tag, "_trigcfg"}, 32'(TrigCfg), 32'(m_trig));
        for (int c = 1; c <= NUM_CH; c++)
            chk($sformatf("%s_ch%0d", tag, c), 32'(CHTrigCfg[5*(c-1) +: 5]), 32'(m_ch[c]));
        chk({tag, "_decim"}, 32'(decimator), 32'(m_dec));
        chk({tag, "_vih"}, 32'(VIH), 32'(m_vih));
        chk({tag, "_vil"}, 32'(VIL), 32'(m_vil));
        chk({tag, "_match"}, 32'(match), 32'(m_match));
        chk({tag, "_mask"}, 32'(mask), 32'(m_mask));
        chk({tag, "_baud"}, 32'(baud_cnt), 32'(m_baud));
        chk({tag, "_tpos"}, 32'(trig_pos), 32'(m_tpos));
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_clr(input string name);
        int budget = 0;
        while (!clr_cmd_rdy && budget < 20000) begin
            @(negedge clk);
            budget++;
        end
        chk({name, "_retired"}, 32'(clr_cmd_rdy), 32'd1);
        cmd_rdy = 1'b0;
        n_cmds++;
    endtask

    task automatic do_cmd(input logic [15:0] c);
        push_expected(c);
        @(negedge clk);
        cmd = c;
        cmd_rdy = 1'b1;
        wait_clr($sformatf("cmd_%04h", c));
    endtask

    task automatic pulse_capture_done();
        @(negedge clk);
        set_capture_done = 1'b1;
        m_trig[5] = 1'b1;
        m_trig[4] = 1'b0;
        @(negedge clk);
        set_capture_done = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] c;
        int sel, a, clr_before;
        int bad_ch[3] = '{0, 6, 7};

        for (int k = 0; k < NUM_CH; k++)
            for (int i = 0; i < ENTRIES; i++) mem[k][i] = 8'($urandom);
        model_reset();

        repeat (3) @(negedge clk);
        chk("rst_resp", 32'(resp), 32'h0);
        chk("rst_send", 32'(send_resp), 32'h0);
        chk("rst_clr", 32'(clr_cmd_rdy), 32'h0);
        chk("rst_raddr", 32'(raddr), 32'h0);
        check_outputs("rst");
        rst_n = 1'b1;

        // Baud counter read-back after reset.
        do_cmd(16'h1000);
        do_cmd(16'h1100);

        // Write VIH with cycle-exact timing, then read it back.
        c = 16'h4A80;
        push_expected(c);
        @(negedge clk);
        cmd = c;
        cmd_rdy = 1'b1;
        @(negedge clk);
        chk("wr_exec_no_send", 32'(send_resp), 32'd0);
        @(negedge clk);
        chk("wr_send_k1", 32'(send_resp), 32'd1);
        chk("wr_vih_before", 32'(VIH), 32'hAA);
        @(negedge clk);
        chk("wr_vih_k2", 32'(VIH), 32'h80);
        wait_clr("wr_vih");
        do_cmd(16'h0A00);

        // Unmapped channel address and NAK opcode.
        do_cmd(16'h0700);
        do_cmd(16'hC512);
        check_outputs("nak");

        // Random register traffic, including invalid single-channel dumps.
        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 9);
            a = ($urandom_range(0, 7) == 0) ? 63 : $urandom_range(0, 21);
            if (sel <= 3)      c = {2'b00, 6'(a), 8'($urandom)};
            else if (sel <= 7) c = {2'b01, 6'(a), 8'($urandom)};
            else if (sel == 8) c = {2'b11, 6'(a), 8'($urandom)};
            else c = {2'b10, 2'b00, 1'b0, 3'(bad_ch[$urandom_range(0, 2)]), 8'($urandom)};
            do_cmd(c);
            check_outputs("rand");
        end

        // Single-channel dump across the wrap point.
        waddr = LOG2'(380);
        do_cmd(16'h8300);
        chk("dump_ch3_last_raddr", 32'(raddr), 32'd379);

        // Capture done while idle, after setting TrigCfg[4].
        do_cmd(16'h401F);
        pulse_capture_done();
        @(negedge clk);
        check_outputs("capdone_idle");

        // TrigCfg write landing in the same cycle as capture done.
        c = 16'h4015;
        push_expected(c);
        @(negedge clk);
        cmd = c;
        cmd_rdy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        set_capture_done = 1'b1;
        @(negedge clk);
        set_capture_done = 1'b0;
        chk("capdone_vs_write", 32'(TrigCfg), 32'h15);
        wait_clr("capdone_vs_write");

        // All-channel dump with capture done arriving mid-stream.
        waddr = LOG2'($urandom_range(0, ENTRIES - 1));
        fork
            do_cmd(16'h8800);
            begin
                repeat (300) @(negedge clk);
                pulse_capture_done();
            end
        join
        check_outputs("dump_all");
        chk("dump_all_trig54", 32'(TrigCfg[5:4]), 32'h2);

        // Reset in the middle of a dump: no retire pulse, reset values back.
        clr_before = clr_seen;
        waddr = LOG2'($urandom_range(0, ENTRIES - 1));
        push_expected(16'h8800);
        @(negedge clk);
        cmd = 16'h8800;
        cmd_rdy = 1'b1;
        repeat (60) @(negedge clk);
        rst_n = 1'b0;
        cmd_rdy = 1'b0;
        exp_q.delete();
        model_reset();
        #1;
        chk("midrst_raddr", 32'(raddr), 32'h0);
        chk("midrst_resp", 32'(resp), 32'h0);
        chk("midrst_send", 32'(send_resp), 32'h0);
        check_outputs("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("midrst_no_clr", 32'(clr_seen), 32'(clr_before));
        do_cmd(16'h1100);

        repeat (10) @(negedge clk);
        chk("clr_count", 32'(clr_seen), 32'(n_cmds));
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
